// File: rtl/vga_plot_scheduler.sv
// vga_plot_scheduler: round-robin arbiter that feeds square pixel blocks
// from several requesters, plus a full-screen clear, into one VGA adapter
// write port. All outputs are decoded from registered state only.
module vga_plot_scheduler #(
   parameter int N_REQ    = 3,
   parameter int BLK_LOG2 = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_x,
   input  logic [7*N_REQ-1:0] req_y,
   input  logic [3*N_REQ-1:0] req_c,
   input  logic               clr_req,
   output logic               clr_done,
   output logic               plot,
   output logic [7:0]         x_out,
   output logic [6:0]         y_out,
   output logic [2:0]         c_out,
   output logic [N_REQ-1:0]   done,
   output logic               busy
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = 2 * BLK_LOG2;
   localparam logic [CW-1:0] CNT_LAST = '1;
   localparam logic [7:0] X_LAST = 8'd159;
   localparam logic [6:0] Y_LAST = 7'd119;

   typedef enum logic [1:0] {S_IDLE, S_BLOCK, S_CLEAR} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      bx_q, bx_d;
   logic [6:0]      by_q, by_d;
   logic [2:0]      bc_q, bc_d;
   logic [7:0]      clr_x_q, clr_x_d;
   logic [6:0]      clr_y_q, clr_y_d;

   logic            found;
   logic [GW-1:0]   winner;
   logic [GW:0]     rr_idx;
   logic [8:0]      sum_x;
   logic [7:0]      sum_y;

   // Round-robin search: scan indices starting just after the last grant.
   always_comb begin
      found  = 1'b0;
      winner = grant_q;
      rr_idx = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         rr_idx = {1'b0, grant_q} + (GW+1)'(i);
         if (rr_idx >= (GW+1)'(N_REQ)) begin
            rr_idx = rr_idx - (GW+1)'(N_REQ);
         end
         if (!found && req[rr_idx[GW-1:0]]) begin
            found  = 1'b1;
            winner = rr_idx[GW-1:0];
         end
      end
   end

   // Next-state logic: clear beats block requests; running operations are never pre-empted.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      bx_d    = bx_q;
      by_d    = by_q;
      bc_d    = bc_q;
      clr_x_d = clr_x_q;
      clr_y_d = clr_y_q;
      case (state_q)
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_CLEAR;
               clr_x_d = '0;
               clr_y_d = '0;
            end else if (found) begin
               state_d = S_BLOCK;
               grant_d = winner;
               cnt_d   = '0;
               bx_d    = req_x[8*winner +: 8];
               by_d    = req_y[7*winner +: 7];
               bc_d    = req_c[3*winner +: 3];
            end
         end
         S_BLOCK: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (clr_x_q == X_LAST) begin
               clr_x_d = '0;
               if (clr_y_q == Y_LAST) begin
                  clr_y_d = '0;
                  state_d = S_IDLE;
               end else begin
                  clr_y_d = clr_y_q + 1'b1;
               end
            end else begin
               clr_x_d = clr_x_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset leaves requester 0 next in line.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         grant_q <= GW'(N_REQ - 1);
         cnt_q   <= '0;
         bx_q    <= '0;
         by_q    <= '0;
         bc_q    <= '0;
         clr_x_q <= '0;
         clr_y_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         bc_q    <= bc_d;
         clr_x_q <= clr_x_d;
         clr_y_q <= clr_y_d;
      end
   end

   // Extra top bit catches wrap-around past the 8/7-bit coordinate range.
   assign sum_x = {1'b0, bx_q} + 9'(cnt_q[BLK_LOG2-1:0]);
   assign sum_y = {1'b0, by_q} + 8'(cnt_q[CW-1:BLK_LOG2]);

   // Output decode from registered state; off-screen block pixels are suppressed.
   always_comb begin
      plot     = 1'b0;
      x_out    = '0;
      y_out    = '0;
      c_out    = '0;
      done     = '0;
      clr_done = 1'b0;
      busy     = (state_q != S_IDLE);
      case (state_q)
         S_BLOCK: begin
            x_out = sum_x[7:0];
            y_out = sum_y[6:0];
            c_out = bc_q;
            plot  = !sum_x[8] && (sum_x[7:0] <= X_LAST) &&
                    !sum_y[7] && (sum_y[6:0] <= Y_LAST);
            if (cnt_q == CNT_LAST) begin
               done[grant_q] = 1'b1;
            end
         end
         S_CLEAR: begin
            x_out    = clr_x_q;
            y_out    = clr_y_q;
            plot     = 1'b1;
            clr_done = (clr_x_q == X_LAST) && (clr_y_q == Y_LAST);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Testbench for vga_plot_scheduler: expected pixels and grant events are
// queued when stimulus is driven and consumed when the DUT plots/pulses.
module tb_vga_plot_scheduler;

   localparam int N = 3;

   logic         clk = 1'b0;
   logic         resetn;
   logic [N-1:0] req;
   logic [8*N-1:0] req_x;
   logic [7*N-1:0] req_y;
   logic [3*N-1:0] req_c;
   logic         clr_req;
   logic         clr_done;
   logic         plot;
   logic [7:0]   x_out;
   logic [6:0]   y_out;
   logic [2:0]   c_out;
   logic [N-1:0] done;
   logic         busy;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t exp_pix[$];
   int   exp_ev[$];   // requester index, or N for a completed clear
   int   n_cmp  = 0;
   int   n_fail = 0;

   vga_plot_scheduler #(.N_REQ(N), .BLK_LOG2(2)) dut (
      .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
      .req_c(req_c), .clr_req(clr_req), .clr_done(clr_done), .plot(plot),
      .x_out(x_out), .y_out(y_out), .c_out(c_out), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic set_slot(input int i, input int x, input int y, input int c);
      req_x[8*i +: 8] = 8'(x);
      req_y[7*i +: 7] = 7'(y);
      req_c[3*i +: 3] = 3'(c);
   endtask

   // Queue the first ncnt pixels of requester i's 4x4 block (on-screen only).
   task automatic push_pixels(input int i, input int ncnt);
      int bx, by, px, py;
      pix_t p;
      bx = int'(req_x[8*i +: 8]);
      by = int'(req_y[7*i +: 7]);
      for (int k = 0; k < ncnt; k++) begin
         px = bx + (k % 4);
         py = by + (k / 4);
         if (px < 160 && py < 120) begin
            p.x = 8'(px); p.y = 7'(py); p.c = req_c[3*i +: 3];
            exp_pix.push_back(p);
         end
      end
   endtask

   task automatic push_block(input int i);
      push_pixels(i, 16);
      exp_ev.push_back(i);
   endtask

   // Scoreboard consumer: every plot pops a pixel, every done/clr_done pops an event.
   task automatic scoreboard_monitor();
      pix_t p;
      int   got, want;
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (plot) begin
               n_cmp++;
               if (exp_pix.size() == 0) begin
                  n_fail++;
                  $display("FAIL pixel: got unexpected plot (%0d,%0d,c%0d), required no plot", x_out, y_out, c_out);
               end else begin
                  p = exp_pix.pop_front();
                  if ({x_out, y_out, c_out} !== p) begin
                     n_fail++;
                     $display("FAIL pixel: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)", x_out, y_out, c_out, p.x, p.y, p.c);
                  end
               end
            end
            if (done !== '0 || clr_done) begin
               got = N;
               for (int i = 0; i < N; i++) if (done[i]) got = i;
               n_cmp++;
               if (exp_ev.size() == 0) begin
                  n_fail++;
                  $display("FAIL grant_order: got event %0d (done=%b clr_done=%b), required none", got, done, clr_done);
               end else begin
                  want = exp_ev.pop_front();
                  if (got !== want) begin
                     n_fail++;
                     $display("FAIL grant_order: got event %0d, required %0d (%0d = clear)", got, want, N);
                  end
               end
               if (clr_done) begin
                  n_cmp++;
                  if (x_out !== 8'd159 || y_out !== 7'd119) begin
                     n_fail++;
                     $display("FAIL clr_done_pixel: got (%0d,%0d), required (159,119)", x_out, y_out);
                  end
               end
            end
         end
      end
   endtask

   // Step until n_ev done/clr_done events, dropping requests that completed.
   task automatic run_until(input int n_ev, input logic [N-1:0] drop_mask, input int budget,
                            output bit timeout, output int busy_cyc, output int first_plot,
                            output int plots);
      int ev, cyc;
      ev = 0; cyc = 0; timeout = 1'b0; busy_cyc = 0; first_plot = -1; plots = 0;
      while (ev < n_ev && !timeout) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cyc++;
         if (plot) begin
            plots++;
            if (first_plot < 0) first_plot = cyc;
         end
         if (clr_done) begin
            ev++;
            clr_req = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (done[i]) begin
               ev++;
               if (drop_mask[i]) req[i] = 1'b0;
            end
         end
         if (cyc >= budget) timeout = 1'b1;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({plot, busy, done, clr_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got plot=%b busy=%b done=%b clr_done=%b, required all 0", plot, busy, done, clr_done);
      end
      n_cmp++;
      if ({x_out, y_out, c_out} !== '0) begin
         n_fail++;
         $display("FAIL reset_xyc: got (%0d,%0d,c%0d), required (0,0,c0)", x_out, y_out, c_out);
      end
      resetn = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_busy: got %b, required 0", busy);
      end
   endtask

   task automatic check_drained(input string name);
      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_pix.size() != 0 || exp_ev.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d pixels/%0d events left busy=%b, required 0/0/0", name, exp_pix.size(), exp_ev.size(), busy);
      end
   endtask

   task automatic check_timeout(input string name, input bit to);
      n_cmp++;
      if (to !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_timeout: got timeout=1, required completion within budget", name);
      end
   endtask

   task automatic test_clear();
      bit to; int bc, fp, np;
      pix_t p;
      for (int y = 0; y < 120; y++) begin
         for (int x = 0; x < 160; x++) begin
            p.x = 8'(x); p.y = 7'(y); p.c = 3'd0;
            exp_pix.push_back(p);
         end
      end
      exp_ev.push_back(N);
      push_block(0); push_block(1); push_block(2);
      clr_req = 1'b1; req = 3'b111;
      run_until(4, 3'b111, 20000, to, bc, fp, np);
      check_timeout("clear", to);
      n_cmp++;
      if (bc !== 19200 + 3*16) begin
         n_fail++;
         $display("FAIL clear_busy_cycles: got %0d, required %0d", bc, 19200 + 3*16);
      end
      check_drained("clear");
   endtask

   task automatic test_round_robin();
      bit to; int bc, fp, np;
      push_block(0); push_block(1); push_block(2);
      req = 3'b111;
      run_until(3, 3'b111, 200, to, bc, fp, np);
      check_timeout("rr_111", to);
      check_drained("rr_111");
      push_block(0); push_block(1);
      req = 3'b011;
      run_until(2, 3'b011, 200, to, bc, fp, np);
      check_timeout("rr_011", to);
      check_drained("rr_011");
      push_block(0); push_block(1); push_block(0); push_block(1);
      req = 3'b011;
      run_until(4, 3'b000, 200, to, bc, fp, np);
      req = 3'b000;
      check_timeout("rr_hold", to);
      check_drained("rr_hold");
   endtask

   task automatic test_single();
      bit to; int bc, fp, np;
      push_block(1);
      req = 3'b010;
      run_until(1, 3'b010, 100, to, bc, fp, np);
      check_timeout("single", to);
      n_cmp++;
      if (plot !== 1'b1 || x_out !== 8'd83 || y_out !== 7'd63) begin
         n_fail++;
         $display("FAIL single_done_pixel: got plot=%b (%0d,%0d), required plot=1 (83,63)", plot, x_out, y_out);
      end
      n_cmp++;
      if (bc !== 16 || fp !== 1) begin
         n_fail++;
         $display("FAIL single_timing: got busy=%0d first_plot=%0d, required 16 and 1", bc, fp);
      end
      check_drained("single");
   endtask

   task automatic test_edge();
      bit to; int bc, fp, np;
      set_slot(2, 158, 118, 5);
      push_block(2);
      req = 3'b100;
      run_until(1, 3'b100, 100, to, bc, fp, np);
      check_timeout("edge", to);
      n_cmp++;
      if (bc !== 16 || np !== 4) begin
         n_fail++;
         $display("FAIL edge_counts: got busy=%0d plots=%0d, required 16 and 4", bc, np);
      end
      check_drained("edge");
   endtask

   task automatic test_reset_abort();
      bit to; int bc, fp, np;
      push_block(0);
      req = 3'b001;
      run_until(1, 3'b001, 100, to, bc, fp, np);
      check_timeout("abort_pre", to);
      check_drained("abort_pre");
      push_pixels(1, 8);
      req = 3'b011;
      for (int k = 0; k < 8; k++) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      n_cmp++;
      if (plot !== 1'b0 || busy !== 1'b0 || done !== '0) begin
         n_fail++;
         $display("FAIL abort_async: got plot=%b busy=%b done=%b, required 0 0 000", plot, busy, done);
      end
      push_block(0); push_block(1);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      run_until(2, 3'b011, 100, to, bc, fp, np);
      check_timeout("abort_post", to);
      n_cmp++;
      if (fp !== 1) begin
         n_fail++;
         $display("FAIL abort_restart_latency: got first plot at cycle %0d, required 1", fp);
      end
      check_drained("abort_post");
   endtask

   initial begin
      resetn  = 1'b0;
      req     = '0;
      clr_req = 1'b0;
      req_x   = '0;
      req_y   = '0;
      req_c   = '0;
      set_slot(0, 10, 5, 1);
      set_slot(1, 80, 60, 2);
      set_slot(2, 30, 40, 4);
      fork
         scoreboard_monitor();
      join_none
      test_reset();
      test_clear();
      test_round_robin();
      test_single();
      test_edge();
      test_reset_abort();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_plot_scheduler.md
VGA_PLOT_SCHEDULER -- requirements
Module: vga_plot_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of block requesters (index 0 = erase, 1 = snake, 2 = food).
REQ-002 SHALL have parameter BLK_LOG2, default 2, log2 of square block edge (4x4 block).
REQ-003 SHALL have ports: clk in 1 system clock; resetn in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: req in N_REQ level request per requester; req_x in 8*N_REQ block origin x; req_y in 7*N_REQ block origin y; req_c in 3*N_REQ block colour.
REQ-005 SHALL have ports: clr_req in 1 full-screen clear request; clr_done out 1 one-cycle pulse at last clear pixel.
REQ-006 SHALL have ports: plot out 1 VGA adapter write strobe; x_out out 8 pixel x; y_out out 7 pixel y; c_out out 3 pixel colour.
REQ-007 SHALL have ports: done out N_REQ one-cycle pulse per requester at its last block pixel; busy out 1 high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, BLOCK, CLEAR; all outputs decoded from registers only, with no combinational path from req/clr_req to outputs.
REQ-009 In IDLE with clr_req high, next edge SHALL enter CLEAR; clr_req SHALL beat every req.
REQ-010 In IDLE with clr_req low and any req high, next edge SHALL select a winner round-robin, starting from the index after last_grant, and SHALL latch its x, y, c, update last_grant, clear cnt, enter BLOCK.
REQ-011 last_grant SHALL reset to N_REQ-1, so requester 0 has first priority after reset.
REQ-012 In BLOCK, each cycle SHALL drive x_out = bx + cnt[BLK_LOG2-1:0], y_out = by + cnt[2*BLK_LOG2-1:BLK_LOG2], c_out = latched colour; cnt increments by 1 per cycle from 0 to 2^(2*BLK_LOG2)-1.
REQ-013 plot SHALL be high in BLOCK only when the pixel lies inside the screen, x_out<160 and y_out<120; off-screen pixels are counted but not plotted; the add is 8/7 bits wide and wrap-around is treated as off-screen via a carry check.
REQ-014 On the final cnt value, done[winner] SHALL be high for that one cycle, and the FSM SHALL return to IDLE at the next edge.
REQ-015 Requesters SHALL hold req, x, y, c stable until done; a requester SHALL drop req in the cycle after done, otherwise it is re-arbitrated normally.
REQ-016 Latency: req seen at edge E makes the first plot visible in the cycle after E; a 4x4 block takes 16 cycles plus 1 IDLE cycle.
REQ-017 In CLEAR, the block SHALL sweep row-major x 0..159, y 0..119, c_out=000, plot high every cycle for 19200 cycles; clr_done SHALL be high on pixel (159,119), then IDLE.
REQ-018 req and clr_req changes during BLOCK or CLEAR SHALL be ignored until IDLE; an in-progress operation is never pre-empted.
REQ-019 If req drops mid-BLOCK (protocol violation), the block SHALL still complete and pulse done.

Reset
REQ-020 While resetn=0, asynchronously: state=IDLE, plot=0, busy=0, done=0, clr_done=0, x_out=0, y_out=0, c_out=000, cnt=0, clear counters=0, last_grant=N_REQ-1.
REQ-021 Reset asserted mid-BLOCK or mid-CLEAR SHALL abort immediately with no done/clr_done pulse; after release, operation starts from IDLE.

Verification
REQ-022 req[1]=1, x=80, y=60, c=010 -> 16 plots covering (80..83,60..63) in cnt order, c_out=010, done[1] on the 16th plot cycle, busy low the following cycle.
REQ-023 req=111 held, each requester dropping req after its done -> grants in order 0,1,2; then req=011 asserted again -> order 0,1; then req[0] and req[1] both held continuously -> grants alternate 0,1,0,1.
REQ-024 clr_req=1 and req=111 together in IDLE -> CLEAR first, 19200 plots, c_out=000, clr_done at (159,119), then requester 0 granted.
REQ-025 req[2] with x=158, y=118 -> only (158,118), (159,118), (158,119), (159,119) plotted (4 plots), 16 cycles busy, done[2] pulsed.
REQ-026 resetn pulsed low at cnt=7 of a block -> plot and busy drop without waiting for a clock edge, no done; after release with req still high, the block restarts from cnt=0 with requester 0 priority.
